// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux between four valid/ready producers.
// An owner keeps the mux for up to HOLD_MAX transfers, then one idle bubble precedes the next grant.
module mux_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [3:0]         req_i,
  input  logic [4*WIDTH-1:0] data_i,
  output logic [3:0]         gnt_o,
  output logic [WIDTH-1:0]   data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [1:0]         sel_o,
  output logic               busy_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(HOLD_MAX - 1);

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [4:0] count, count_nxt;

  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      count <= 5'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      count <= count_nxt;
    end
  end

  // First requester found when scanning upward from the pointer, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          ptr_nxt   = pick + 2'd1;
          count_nxt = 5'd0;
        end
      end
      GRANT: begin
        if (!req_i[owner]) begin
          state_nxt = IDLE;
          count_nxt = 5'd0;
        end else if (ready_i) begin
          if (count == LAST_BEAT) begin
            state_nxt = IDLE;
            count_nxt = 5'd0;
          end else begin
            count_nxt = count + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come straight from registered state, so an async reset clears them at once.
  always_comb begin
    gnt_o   = 4'b0000;
    data_o  = '0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    if (state == GRANT) begin
      busy_o       = 1'b1;
      valid_o      = req_i[owner];
      data_o       = data_i[int'(owner)*WIDTH +: WIDTH];
      gnt_o[owner] = ready_i;
    end
  end

  assign sel_o = owner;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one HOLD_MAX=4 instance for most scenarios,
// a HOLD_MAX=1 instance driven in parallel for the rotation scenario.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data = 32'h0;
  logic        ready = 1'b0;

  logic [3:0] gnt4, gnt1;
  logic [7:0] dout4, dout1;
  logic       valid4, valid1, busy4, busy1;
  logic [1:0] sel4, sel1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .data_i(data),
    .gnt_o(gnt4), .data_o(dout4), .valid_o(valid4), .ready_i(ready),
    .sel_o(sel4), .busy_o(busy4)
  );

  mux_rr_arbiter #(.WIDTH(8), .HOLD_MAX(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .data_i(data),
    .gnt_o(gnt1), .data_o(dout1), .valid_o(valid1), .ready_i(ready),
    .sel_o(sel1), .busy_o(busy1)
  );

  // Leaves both instances in IDLE with pointer 0, positioned just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    data  = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    ready = 1'b1;
    data  = 32'h44332211;
    #1;
    checks++; if (sel4 !== 2'd0) begin failures++; $display("[TB] FAIL reset_sel got=%0d exp=0", sel4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy4); end
    checks++; if (valid4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", valid4); end
    checks++; if (gnt4 !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=0000", gnt4); end
    checks++; if (dout4 !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", dout4); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_after_release got=%0b exp=0", busy4); end
    @(negedge clk);
    #1;
    checks++; if (busy4 !== 1'b1 || sel4 !== 2'd0) begin failures++; $display("[TB] FAIL reset_first_owner busy=%0b sel=%0d exp busy=1 sel=0", busy4, sel4); end
    checks++; if (dout4 !== 8'h11) begin failures++; $display("[TB] FAIL reset_first_data got=%h exp=11", dout4); end
  endtask

  task automatic test_single_burst();
    do_reset();
    req   = 4'b0010;
    ready = 1'b1;
    data  = {16'h0, 8'h10, 8'h0};
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL burst_idle got=%0b exp=0", busy4); end
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      if (b == 4) begin
        #1;
        checks++; if (busy4 !== 1'b0 || valid4 !== 1'b0 || gnt4 !== 4'b0000) begin failures++; $display("[TB] FAIL burst_bubble busy=%0b valid=%0b gnt=%b exp 0/0/0000", busy4, valid4, gnt4); end
        @(negedge clk);
      end
      data[15:8] = 8'h10 + 8'(b);
      #1;
      checks++; if (gnt4 !== 4'b0010 || sel4 !== 2'd1 || valid4 !== 1'b1) begin failures++; $display("[TB] FAIL burst_beat%0d gnt=%b sel=%0d valid=%0b exp 0010/1/1", b, gnt4, sel4, valid4); end
      checks++; if (dout4 !== 8'h10 + 8'(b)) begin failures++; $display("[TB] FAIL burst_data%0d got=%h exp=%h", b, dout4, 8'h10 + 8'(b)); end
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++; if (busy4 !== 1'b1 || valid4 !== 1'b0) begin failures++; $display("[TB] FAIL burst_drop busy=%0b valid=%0b exp 1/0", busy4, valid4); end
    @(negedge clk);
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL burst_release got=%0b exp=0", busy4); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel;
    do_reset();
    req   = 4'b1111;
    ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_sel = 2'(g % 4);
      #1;
      checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL rotation_bubble%0d got=%0b exp=0", g, busy1); end
      @(negedge clk);
      #1;
      checks++; if (busy1 !== 1'b1 || sel1 !== exp_sel) begin failures++; $display("[TB] FAIL rotation_grant%0d busy=%0b sel=%0d exp busy=1 sel=%0d", g, busy1, sel1, exp_sel); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req   = 4'b0100;
    ready = 1'b0;
    data  = {8'h0, 8'hA5, 16'h0};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++; if (valid4 !== 1'b1 || dout4 !== 8'hA5 || gnt4 !== 4'b0000 || busy4 !== 1'b1) begin failures++; $display("[TB] FAIL stall%0d valid=%0b data=%h gnt=%b busy=%0b exp 1/a5/0000/1", c, valid4, dout4, gnt4, busy4); end
    end
    // A full HOLD_MAX burst after the stall shows the stalled cycles were not counted.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ready = 1'b1;
      #1;
      checks++; if (gnt4 !== 4'b0100 || busy4 !== 1'b1) begin failures++; $display("[TB] FAIL bp_transfer%0d gnt=%b busy=%0b exp 0100/1", c, gnt4, busy4); end
    end
    @(negedge clk);
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL bp_release got=%0b exp=0", busy4); end
  endtask

  task automatic test_early_release();
    do_reset();
    req   = 4'b1001;
    ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++; if (gnt4 !== 4'b0001 || sel4 !== 2'd0) begin failures++; $display("[TB] FAIL early_transfer%0d gnt=%b sel=%0d exp 0001/0", c, gnt4, sel4); end
    end
    @(negedge clk);
    req = 4'b1000;
    #1;
    checks++; if (valid4 !== 1'b0 || busy4 !== 1'b1) begin failures++; $display("[TB] FAIL early_drop valid=%0b busy=%0b exp 0/1", valid4, busy4); end
    @(negedge clk);
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL early_idle got=%0b exp=0", busy4); end
    @(negedge clk);
    #1;
    checks++; if (busy4 !== 1'b1 || sel4 !== 2'd3 || gnt4 !== 4'b1000) begin failures++; $display("[TB] FAIL early_next_owner busy=%0b sel=%0d gnt=%b exp 1/3/1000", busy4, sel4, gnt4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req   = 4'b0100;
    ready = 1'b1;
    data  = {8'h0, 8'h5A, 16'h0};
    @(negedge clk);
    #1;
    checks++; if (busy4 !== 1'b1 || sel4 !== 2'd2) begin failures++; $display("[TB] FAIL async_pre busy=%0b sel=%0d exp 1/2", busy4, sel4); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy4 !== 1'b0 || valid4 !== 1'b0 || gnt4 !== 4'b0000 || dout4 !== 8'h00) begin failures++; $display("[TB] FAIL async_clear busy=%0b valid=%0b gnt=%b data=%h exp 0/0/0000/00", busy4, valid4, gnt4, dout4); end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0101;
    @(negedge clk);
    #1;
    checks++; if (busy4 !== 1'b1 || sel4 !== 2'd0) begin failures++; $display("[TB] FAIL async_regrant busy=%0b sel=%0d exp 1/0", busy4, sel4); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rotation();
    test_backpressure();
    test_early_release();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one 4:1 data mux between four requesters using round-robin arbitration with bounded burst ownership.
- Drives the mux select, steers the owning requester's data to a single valid/ready output, and returns per-requester grant/ready.
- Sits between four producer blocks and one downstream consumer on the iCE40 fabric.

Parameters:
- WIDTH, 8, data width per requester and of data_o.
- HOLD_MAX, 4, max transfers per ownership before forced release; legal range 1..16.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- req_i  input  4  per-requester valid; bit k = requester k has data.
- data_i  input  4*WIDTH  packed data; requester k at [k*WIDTH +: WIDTH].
- gnt_o  output  4  per-requester ready; at most one bit high.
- data_o  output  WIDTH  muxed data of current owner.
- valid_o  output  1  data_o valid toward consumer.
- ready_i  input  1  consumer ready.
- sel_o  output  2  current owner index, i.e. the mux select.
- busy_o  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_n_i is asynchronous, active-low.
- Reset values: state IDLE, owner 0, rr pointer 0, beat count 0. Outputs: sel_o=0, busy_o=0, valid_o=0, gnt_o=0, data_o=0.
- Reset mid-burst: all outputs clear immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE, no request: if req_i==0, stay IDLE.
- IDLE, arbitration: search req_i starting at the rr pointer, then pointer+1, pointer+2, pointer+3 (mod 4).
  - First set bit k becomes owner.
  - Registered on the edge: sel_o<=k, ptr<=(k+1) mod 4, count<=0, state<=GRANT.
  - Arbitration latency: 1 cycle from req seen in IDLE to busy_o high.
- IDLE outputs: valid_o=0, gnt_o=0, data_o=0, busy_o=0.
- GRANT outputs (combinational from registered owner k):
  - valid_o=req_i[k].
  - data_o=data_i[k*WIDTH +: WIDTH].
  - gnt_o[k]=ready_i, other gnt_o bits 0.
  - busy_o=1, sel_o=k.
- Transfer: a cycle in GRANT with req_i[k]=1 and ready_i=1. Each transfer increments count.
- Release to IDLE on the edge ending a GRANT cycle, if either:
  - req_i[k]=0, i.e. owner dropped request (no transfer that cycle), or
  - a transfer occurs with count==HOLD_MAX-1.
  - Release clears count. State returns to IDLE, giving a 1-cycle bubble before the next grant.
- Backpressure: while ready_i=0, the owner is held, count is unchanged, and data_o tracks the owner's data_i.
  - Requesters hold data stable while req high and gnt low.
- Non-owner requests during GRANT are ignored until the next IDLE cycle.
- Fairness: the pointer always moves past the last owner. A requester waits at most 3 ownerships.
- HOLD_MAX=1 gives single-beat interleaving with a bubble between beats.
- Pointer wrap: owner 3 sets ptr to 0.
- Simultaneous release and new requests: the new requests are evaluated in the following IDLE cycle, not the release cycle.

Test Plan:
- Reset: assert rst_n_i=0 with req_i=4'b1111 -> sel_o=0, busy_o=0, valid_o=0, gnt_o=0, data_o=0. After release, first owner is requester 0, with busy_o high 1 cycle later.
- Single burst, HOLD_MAX=4: req_i=4'b0010 held with 6 beats queued, ready_i=1.
  - 4 transfers with gnt_o=4'b0010, sel_o=1.
  - Then 1 IDLE bubble, re-grant to requester 1, 2 more transfers.
  - Requester drops req -> IDLE.
- Rotation: req_i=4'b1111 held, ready_i=1, HOLD_MAX=1 -> sel_o sequence 0,1,2,3,0 on successive grants, with an IDLE cycle between each.
- Backpressure: owner 2, data_i slice=8'hA5, ready_i=0 for 3 cycles.
  - valid_o=1, data_o=8'hA5, gnt_o=0 throughout, count unchanged.
  - Then ready_i=1 -> gnt_o=4'b0100 and transfer counted.
- Early release: owner 0 drops req after 2 transfers while req_i[3]=1 -> IDLE next edge, then owner 3 (ptr=1 search finds 3), sel_o=3.
- Async reset mid-burst: rst_n_i low between clock edges during GRANT with owner 2 -> busy_o, valid_o, gnt_o drop immediately. After reset, ptr=0, so req_i=4'b0101 grants requester 0.
